// File: rtl/controle_execucao_pkg.sv
// Shared definitions for the execution sequencer of the single-cycle ARM core:
// sequencer state encodings, ALU op codes shared with the decoder/ALU, and a
// width helper for small counters.
package controle_execucao_pkg;

  typedef enum logic [2:0] {
    INICIO    = 3'd0,
    EXECUTA   = 3'd1,
    ESPERA_IN = 3'd2,
    DIVIDE    = 3'd3,
    PARADO    = 3'd4
  } estado_t;

  localparam logic [3:0] ULA_UDIV = 4'b0100;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int largura_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/controle_execucao_if.sv
// Bundle of decoder control lines, the raw confirm button and the
// sequencer's enables/status outputs.
interface controle_execucao_if;
  import controle_execucao_pkg::*;

  logic       CTRLHalt;
  logic       CTRLCLK;
  logic       CTRLSaida;
  logic [3:0] CTRLOpULA;
  logic       CTRLEscritaReg;
  logic       Botao;

  logic       Inibe;
  logic       HabilitaPC;
  logic       HabilitaEscrita;
  logic       PulsoSaida;
  logic       LEDEspera;
  logic       Parado;
  logic [2:0] Estado;

  modport slave (
    input  CTRLHalt, CTRLCLK, CTRLSaida, CTRLOpULA, CTRLEscritaReg, Botao,
    output Inibe, HabilitaPC, HabilitaEscrita, PulsoSaida, LEDEspera, Parado, Estado
  );

  modport master (
    output CTRLHalt, CTRLCLK, CTRLSaida, CTRLOpULA, CTRLEscritaReg, Botao,
    input  Inibe, HabilitaPC, HabilitaEscrita, PulsoSaida, LEDEspera, Parado, Estado
  );

endinterface

// File: rtl/controle_execucao_debounce_botao.sv
// Confirm-button conditioner: two-flop synchronizer, polarity correction,
// debounce counter and a single-cycle pulse on each accepted press.
module debounce_botao
  import controle_execucao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic botao,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

  logic          sinc1;
  logic          sinc2;
  logic          estavel;
  logic [CW-1:0] cont;

  // Bring the raw button into the clock domain, normalised so 1 = pressed.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
    end else begin
      sinc1 <= botao ^ BOTAO_ATIVO_BAIXO;
      sinc2 <= sinc1;
    end
  end

  // Accept a new level only after an unbroken run of disagreeing samples;
  // a press (released->pressed) produces exactly one pulse cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cont    <= '0;
      estavel <= 1'b0;
      pulso   <= 1'b0;
    end else if (sinc2 == estavel) begin
      cont  <= '0;
      pulso <= 1'b0;
    end else if (cont == LIMITE) begin
      cont    <= '0;
      estavel <= sinc2;
      pulso   <= sinc2;
    end else begin
      cont  <= cont + 1'b1;
      pulso <= 1'b0;
    end
  end

endmodule

// File: rtl/controle_execucao.sv
// Execution sequencer: drives the decoder's Inibe, gates PC load and register
// write-back, stalls for HLT / IN / multi-cycle UDIV and pulses the output
// latch for OUT.
module controle_execucao
  import controle_execucao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int DIV_CYCLES        = 4,
  parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  controle_execucao_if.slave bus
);

  localparam int DW             = largura_min1(DIV_CYCLES);
  localparam int DIV_CARGA_INT  = (DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0;
  localparam logic [DW-1:0] DIV_CARGA = DW'(DIV_CARGA_INT);
  localparam bit DIV_MULTI      = (DIV_CYCLES > 1);

  estado_t       estado;
  estado_t       estado_prox;
  logic [DW-1:0] div_cont;
  logic [DW-1:0] div_prox;
  logic          pulso_botao;
  logic          eh_udiv;
  logic          hab_pc;
  logic          hab_escrita;
  logic          pulso_saida;

  debounce_botao #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .BOTAO_ATIVO_BAIXO(BOTAO_ATIVO_BAIXO)
  ) u_debounce (
    .Clock(Clock),
    .Reset(Reset),
    .botao(bus.Botao),
    .pulso(pulso_botao)
  );

  // A UDIV that writes back only stalls when the divider needs several cycles.
  assign eh_udiv = (bus.CTRLOpULA == ULA_UDIV) && bus.CTRLEscritaReg && DIV_MULTI;

  // State register and divide countdown.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado   <= INICIO;
      div_cont <= '0;
    end else begin
      estado   <= estado_prox;
      div_cont <= div_prox;
    end
  end

  // Next state and the Mealy enables; enables only rise in a committing cycle.
  always_comb begin
    estado_prox = estado;
    div_prox    = div_cont;
    hab_pc      = 1'b0;
    hab_escrita = 1'b0;
    pulso_saida = 1'b0;
    case (estado)
      INICIO: begin
        estado_prox = EXECUTA;
      end
      EXECUTA: begin
        if (bus.CTRLHalt) begin
          estado_prox = PARADO;
        end else if (bus.CTRLCLK) begin
          estado_prox = ESPERA_IN;
        end else if (eh_udiv) begin
          div_prox    = DIV_CARGA;
          estado_prox = DIVIDE;
        end else begin
          hab_pc      = 1'b1;
          hab_escrita = 1'b1;
          pulso_saida = bus.CTRLSaida;
        end
      end
      ESPERA_IN: begin
        if (pulso_botao) begin
          hab_pc      = 1'b1;
          hab_escrita = 1'b1;
          estado_prox = EXECUTA;
        end
      end
      DIVIDE: begin
        if (div_cont == '0) begin
          hab_pc      = 1'b1;
          hab_escrita = 1'b1;
          estado_prox = EXECUTA;
        end else begin
          div_prox = div_cont - 1'b1;
        end
      end
      PARADO: begin
        estado_prox = PARADO;
      end
      default: begin
        estado_prox = INICIO;
      end
    endcase
  end

  assign bus.HabilitaPC      = hab_pc;
  assign bus.HabilitaEscrita = hab_escrita;
  assign bus.PulsoSaida      = pulso_saida;
  assign bus.Inibe           = (estado == INICIO) || (estado == PARADO);
  assign bus.LEDEspera       = (estado == ESPERA_IN);
  assign bus.Parado          = (estado == PARADO);
  assign bus.Estado          = estado;

endmodule

// File: tb/tb_controle_execucao.sv
// Randomised bench for controle_execucao: two instances (4-cycle and 1-cycle
// UDIV) share decoder/button stimulus and are compared every cycle against a
// behavioural model of the sequencer and the debounced button.
module tb_controle_execucao;

  localparam int DEB    = 4;
  localparam int CICLOS = 4000;

  typedef enum int {M_BOOT, M_RUN, M_WAIT, M_DIV, M_HALT} fase_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  int total = 0;
  int bad   = 0;

  fase_t fase[2];
  int    resta[2];
  int    div_de[2] = '{4, 1};
  logic  pulso_m;
  logic  estavel_m;
  logic  brutos[$];
  logic  vistos[$];

  logic       c_halt, c_in, c_saida, c_escr, c_press;
  logic [3:0] c_op;
  int         reset_ciclos;
  int         botao_resta;

  controle_execucao_if bus_a ();
  controle_execucao_if bus_b ();

  controle_execucao #(.DEBOUNCE_CYCLES(DEB), .DIV_CYCLES(4), .BOTAO_ATIVO_BAIXO(1'b1)) dut_a (
    .Clock(Clock), .Reset(Reset), .bus(bus_a.slave));

  controle_execucao #(.DEBOUNCE_CYCLES(DEB), .DIV_CYCLES(1), .BOTAO_ATIVO_BAIXO(1'b1)) dut_b (
    .Clock(Clock), .Reset(Reset), .bus(bus_b.slave));

  // Free-running 10-unit clock.
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] codigo(input fase_t f);
    case (f)
      M_BOOT:  return 3'd0;
      M_RUN:   return 3'd1;
      M_WAIT:  return 3'd2;
      M_DIV:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  task automatic applyStimulus(input logic h, input logic c, input logic s,
                               input logic [3:0] op, input logic e, input logic p);
    c_halt = h; c_in = c; c_saida = s; c_op = op; c_escr = e; c_press = p;
    bus_a.CTRLHalt = h; bus_a.CTRLCLK = c; bus_a.CTRLSaida = s;
    bus_a.CTRLOpULA = op; bus_a.CTRLEscritaReg = e; bus_a.Botao = ~p;
    bus_b.CTRLHalt = h; bus_b.CTRLCLK = c; bus_b.CTRLSaida = s;
    bus_b.CTRLOpULA = op; bus_b.CTRLEscritaReg = e; bus_b.Botao = ~p;
  endtask

  task automatic modeloReset();
    for (int i = 0; i < 2; i++) begin
      fase[i]  = M_BOOT;
      resta[i] = 0;
    end
    pulso_m   = 1'b0;
    estavel_m = 1'b0;
    brutos    = {1'b0, 1'b0};
    vistos    = {};
    for (int k = 0; k < DEB; k++) vistos.push_back(1'b0);
  endtask

  // One clock edge of the reference: instruction flow first (uses the pulse
  // visible before the edge), then the button history.
  task automatic modeloPasso();
    logic s;
    bit   todos;
    for (int i = 0; i < 2; i++) begin
      logic udiv;
      udiv = (c_op == 4'b0100) && c_escr && (div_de[i] > 1);
      case (fase[i])
        M_BOOT: fase[i] = M_RUN;
        M_RUN: begin
          if (c_halt)    fase[i] = M_HALT;
          else if (c_in) fase[i] = M_WAIT;
          else if (udiv) begin
            fase[i]  = M_DIV;
            resta[i] = div_de[i] - 1;
          end
        end
        M_WAIT: if (pulso_m) fase[i] = M_RUN;
        M_DIV: begin
          if (resta[i] == 1) fase[i] = M_RUN;
          else resta[i]--;
        end
        default: ;
      endcase
    end
    s = brutos.pop_front();
    brutos.push_back(c_press);
    vistos.push_back(s);
    if (vistos.size() > DEB) void'(vistos.pop_front());
    todos = 1'b1;
    foreach (vistos[k]) if (vistos[k] == estavel_m) todos = 1'b0;
    pulso_m = 1'b0;
    if (todos) begin
      estavel_m = s;
      pulso_m   = s;
    end
  endtask

  task automatic confere(input int i, input logic [2:0] est, input logic ini, input logic pc,
                         input logic esc, input logic ps, input logic led, input logic par);
    logic udiv, commit, saida;
    udiv   = (c_op == 4'b0100) && c_escr && (div_de[i] > 1);
    commit = 1'b0;
    saida  = 1'b0;
    case (fase[i])
      M_RUN: if (!c_halt && !c_in && !udiv) begin
        commit = 1'b1;
        saida  = c_saida;
      end
      M_WAIT: commit = pulso_m;
      M_DIV:  commit = (resta[i] == 1);
      default: ;
    endcase
    checkOutput($sformatf("dut%0d.Estado", i), 32'(est), 32'(codigo(fase[i])));
    checkOutput($sformatf("dut%0d.Inibe", i), 32'(ini), 32'(fase[i] == M_BOOT || fase[i] == M_HALT));
    checkOutput($sformatf("dut%0d.HabilitaPC", i), 32'(pc), 32'(commit));
    checkOutput($sformatf("dut%0d.HabilitaEscrita", i), 32'(esc), 32'(commit));
    checkOutput($sformatf("dut%0d.PulsoSaida", i), 32'(ps), 32'(saida));
    checkOutput($sformatf("dut%0d.LEDEspera", i), 32'(led), 32'(fase[i] == M_WAIT));
    checkOutput($sformatf("dut%0d.Parado", i), 32'(par), 32'(fase[i] == M_HALT));
  endtask

  task automatic confereAmbos();
    confere(0, bus_a.Estado, bus_a.Inibe, bus_a.HabilitaPC, bus_a.HabilitaEscrita,
            bus_a.PulsoSaida, bus_a.LEDEspera, bus_a.Parado);
    confere(1, bus_b.Estado, bus_b.Inibe, bus_b.HabilitaPC, bus_b.HabilitaEscrita,
            bus_b.PulsoSaida, bus_b.LEDEspera, bus_b.Parado);
  endtask

  task automatic geraEntradas(input bit forca_halt);
    logic       c, s, e, p;
    logic [3:0] op;
    c  = forca_halt ? 1'b1 : ($urandom_range(0, 99) < 12);
    s  = ($urandom_range(0, 99) < 25);
    op = ($urandom_range(0, 99) < 30) ? 4'b0100 : 4'($urandom_range(0, 15));
    e  = 1'($urandom_range(0, 1));
    p  = c_press;
    if (botao_resta == 0) begin
      p = ~c_press;
      botao_resta = $urandom_range(1, 14);
    end
    botao_resta--;
    applyStimulus(forca_halt, c, s, op, e, p);
  endtask

  // Drive, check at the falling edge, then advance the model past the rising edge.
  task automatic umCiclo(input bit forca_halt);
    geraEntradas(forca_halt);
    @(negedge Clock);
    confereAmbos();
    if (Reset == 1'b0) begin
      if (reset_ciclos <= 1) Reset = 1'b1;
      else reset_ciclos--;
    end
    @(posedge Clock);
    #1;
    if (Reset) modeloPasso();
  endtask

  // Asynchronous reset mid-cycle; state must clear without waiting for a clock.
  task automatic pulsoReset(input int n);
    Reset = 1'b0;
    #1;
    modeloReset();
    confereAmbos();
    reset_ciclos = n;
  endtask

  initial begin
    c_press     = 1'b0;
    botao_resta = 5;
    modeloReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    pulsoReset(4);
    for (int k = 0; k < CICLOS; k++) begin
      umCiclo(1'b0);
      if (Reset && ($urandom_range(0, (fase[0] == M_DIV) ? 3 : 299) == 0))
        pulsoReset($urandom_range(1, 2));
    end
    pulsoReset(1);
    for (int k = 0; k < 110; k++) umCiclo(k < 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_execucao.md
Name: controle_execucao

Overview:
Execution sequencer for the single-cycle ARM-32bit core; sits between the instruction decoder's control outputs and the PC/register file.
- Generates the decoder's Inibe input.
- Gates PC update and register write-back.
- Stalls the core for HLT, IN (waits for a debounced user button) and multi-cycle UDIV.
- Emits a one-cycle output-latch pulse for OUT.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the button state is accepted
DIV_CYCLES, 4, cycles UDIV occupies; 1 means no stall
BOTAO_ATIVO_BAIXO, 1, 1 = raw button is active-low (DE2 KEY)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
CTRLHalt  in  1  decoder: HLT decoded
CTRLCLK  in  1  decoder: IN decoded
CTRLSaida  in  1  decoder: OUT decoded
CTRLOpULA  in  4  decoder: ALU op; 4'b0100 = UDIV
CTRLEscritaReg  in  1  decoder: register write requested
Botao  in  1  raw asynchronous confirm button
Inibe  out  1  to decoder; 1 forces all control signals to zero
HabilitaPC  out  1  PC load enable
HabilitaEscrita  out  1  register-file write enable; the register file uses CTRLEscritaReg AND HabilitaEscrita
PulsoSaida  out  1  one-cycle enable for the output display register
LEDEspera  out  1  waiting-for-input LED
Parado  out  1  core halted
Estado  out  3  current state encoding, for debug

Behaviour:
- Single clock. Reset is asynchronous and active-low. All flops clear on Reset=0.
- States: INICIO=0, EXECUTA=1, ESPERA_IN=2, DIVIDE=3, PARADO=4.
- Reset state is INICIO. Reset outputs: Inibe=1; HabilitaPC, HabilitaEscrita, PulsoSaida, LEDEspera, Parado = 0; Estado=0; divide counter=0; debouncer stable state = released.
- Inibe, LEDEspera, Parado and Estado are Moore outputs decoded from the state register. This keeps Inibe free of any combinational path from decoder outputs.
- HabilitaPC, HabilitaEscrita and PulsoSaida are Mealy outputs from state plus inputs.
- INICIO: Inibe=1, all enables 0. Next state EXECUTA unconditionally, so the first instruction executes in the 2nd cycle after reset release.
- EXECUTA: Inibe=0. Priority is Halt > IN > UDIV > normal.
  - CTRLHalt=1: enables 0; next PARADO.
  - CTRLCLK=1: enables 0; next ESPERA_IN.
  - CTRLOpULA=4'b0100 & CTRLEscritaReg=1 & DIV_CYCLES>1: enables 0; counter := DIV_CYCLES-2; next DIVIDE.
  - Otherwise: HabilitaPC=1, HabilitaEscrita=1, PulsoSaida=CTRLSaida; stay in EXECUTA.
- ESPERA_IN: Inibe=0, so the decoder keeps IN controls and its own LEDIN asserted; LEDEspera=1.
  - Enables stay 0 until the debouncer press pulse.
  - On the pulse cycle: HabilitaEscrita=1, HabilitaPC=1; next EXECUTA.
- DIVIDE: enables 0 while counter≠0; counter decrements by 1.
  - counter=0: HabilitaEscrita=1, HabilitaPC=1; next EXECUTA.
  - UDIV therefore totals exactly DIV_CYCLES cycles, with the write in the last one.
- PARADO: Inibe=1, Parado=1, enables 0. Only Reset exits this state.
- Debouncer:
  - Botao passes through a 2-flop synchronizer, inverted when BOTAO_ATIVO_BAIXO=1.
  - The stable state takes the synchronized value after DEBOUNCE_CYCLES consecutive cycles of disagreement. Any agreement clears the counter.
  - The press pulse lasts one cycle, on the stable 0→1 transition.
  - A press only fires once. Holding the button across consecutive IN instructions does not re-trigger; each IN needs release then a new press.
  - Pulses outside ESPERA_IN are discarded, never queued.
- Reset asserted mid-stall (ESPERA_IN/DIVIDE): state returns to INICIO immediately. No write occurs.
- Counter width is $clog2(DIV_CYCLES) with a minimum of 1. Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).

Decomposition:
- Shared package constants: state encodings; ULA_UDIV = 4'b0100. The same ALU op codes are reused by the decoder and ALU.
- Sub-module debounce_botao (synchronizer, debounce counter, press pulse; params DEBOUNCE_CYCLES, BOTAO_ATIVO_BAIXO), instantiated once.

Test Plan:
- Reset low 3 cycles, then high; decoder idle: Inibe=1 in cycle 0 after release, 0 in cycle 1; HabilitaPC=1 from cycle 1.
- CTRLCLK=1 in EXECUTA with DEBOUNCE_CYCLES=4: Estado=2, LEDEspera=1, enables 0. Press Botao (drive 0) 3 cycles then release: no write. Press again held 10 cycles: exactly one cycle with HabilitaEscrita=HabilitaPC=1, 4+2 cycles after the press edge; then Estado=1.
- Back-to-back IN with button held from the previous IN: no commit until release plus a new press.
- UDIV (CTRLOpULA=4'b0100, CTRLEscritaReg=1), DIV_CYCLES=4: enables 0 for 3 cycles, 1 in the 4th; repeat with DIV_CYCLES=1: no stall.
- CTRLSaida=1 for one instruction: PulsoSaida=1 for exactly 1 cycle, HabilitaPC=1. CTRLHalt=1 together with CTRLCLK=1: PARADO wins; Inibe=1, Parado=1 persist for 100 cycles.
- Reset pulsed low while in DIVIDE (counter=1): Estado=0 asynchronously, HabilitaEscrita never 1; normal execution resumes.
